// File: rtl/picorv32_vec_mem_arbiter_if.sv
// Native picorv32-style memory bus: one request/response channel between a master and a slave.
// The arbiter uses the slave modport toward each requester and the master modport toward memory.
interface picorv32_vec_mem_arbiter_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv32_vec_mem_arbiter.sv
// Shares one memory port between the picorv32 core and the vector coprocessor.
// Round-robin with a bounded run of consecutive vector grants; one transaction in flight.
module picorv32_vec_mem_arbiter #(
  parameter int unsigned VEC_BURST = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  picorv32_vec_mem_arbiter_if.slave       cpu,
  picorv32_vec_mem_arbiter_if.slave       vec,
  picorv32_vec_mem_arbiter_if.master      mem,
  output logic [1:0]                      grant
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CPU_BUSY = 2'b01,
    ST_VEC_BUSY = 2'b10
  } state_t;

  localparam logic [3:0] LP_BURST = 4'(VEC_BURST);

  state_t     r_state;
  logic       r_last_vec;
  logic [3:0] r_vec_run;

  state_t     w_state_next;
  logic       w_last_vec_next;
  logic [3:0] w_vec_run_next;
  logic [3:0] w_vec_run_inc;
  logic       w_pick_vec;
  logic       w_cpu_own;
  logic       w_vec_own;

  assign w_vec_run_inc = (r_vec_run == 4'hF) ? r_vec_run : r_vec_run + 4'd1;

  // Vector wins a contested IDLE cycle unless it already holds the port for a full run.
  assign w_pick_vec = vec.mem_valid &&
                      (!cpu.mem_valid || !r_last_vec || (r_vec_run < LP_BURST));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_last_vec <= 1'b0;
      r_vec_run  <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_last_vec <= w_last_vec_next;
      r_vec_run  <= w_vec_run_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_last_vec_next = r_last_vec;
    w_vec_run_next  = r_vec_run;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vec) begin
          w_state_next    = ST_VEC_BUSY;
          w_last_vec_next = 1'b1;
          w_vec_run_next  = w_vec_run_inc;
        end else begin
          w_vec_run_next = 4'd0;
          if (cpu.mem_valid) begin
            w_state_next    = ST_CPU_BUSY;
            w_last_vec_next = 1'b0;
          end
        end
      end
      ST_CPU_BUSY, ST_VEC_BUSY: begin
        if (mem.mem_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_cpu_own = (r_state == ST_CPU_BUSY);
  assign w_vec_own = (r_state == ST_VEC_BUSY);

  // The owner's request is passed through combinationally; the bus is quiet in IDLE.
  assign mem.mem_valid = (w_cpu_own & cpu.mem_valid) | (w_vec_own & vec.mem_valid);
  assign mem.mem_instr = w_cpu_own & cpu.mem_instr;
  assign mem.mem_addr  = w_cpu_own ? cpu.mem_addr  : (w_vec_own ? vec.mem_addr  : 32'd0);
  assign mem.mem_wdata = w_cpu_own ? cpu.mem_wdata : (w_vec_own ? vec.mem_wdata : 32'd0);
  assign mem.mem_wstrb = w_cpu_own ? cpu.mem_wstrb : (w_vec_own ? vec.mem_wstrb : 4'd0);

  assign cpu.mem_ready = w_cpu_own & mem.mem_ready;
  assign vec.mem_ready = w_vec_own & mem.mem_ready;
  assign cpu.mem_rdata = mem.mem_rdata;
  assign vec.mem_rdata = mem.mem_rdata;

  assign grant = r_state;

endmodule

// File: tb/tb_picorv32_vec_mem_arbiter.sv
// Bench for picorv32_vec_mem_arbiter: directed traffic against a one-cycle memory model,
// expected grants and read data queued by the stimulus and checked by a monitor.
module tb_picorv32_vec_mem_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  picorv32_vec_mem_arbiter_if cpu_if ();
  picorv32_vec_mem_arbiter_if vec_if ();
  picorv32_vec_mem_arbiter_if mem_if ();
  picorv32_vec_mem_arbiter_if cpu1_if ();
  picorv32_vec_mem_arbiter_if vec1_if ();
  picorv32_vec_mem_arbiter_if mem1_if ();
  logic [1:0] grant;
  logic [1:0] grant1;

  picorv32_vec_mem_arbiter #(.VEC_BURST(4)) dut (
    .clk(clk), .resetn(resetn), .cpu(cpu_if), .vec(vec_if), .mem(mem_if), .grant(grant)
  );

  picorv32_vec_mem_arbiter #(.VEC_BURST(1)) dut1 (
    .clk(clk), .resetn(resetn), .cpu(cpu1_if), .vec(vec1_if), .mem(mem1_if), .grant(grant1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] rdata; bit chk; } rsp_t;
  typedef struct { logic [1:0] g; logic [31:0] addr; logic instr; } gnt_t;
  rsp_t       cpu_q[$];
  rsp_t       vec_q[$];
  gnt_t       gnt_q[$];
  logic [1:0] gnt1_q[$];

  // Memory model: word array, answers one cycle after it sees a request.
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;
  logic        s_ready = 1'b0;
  logic        s_extra = 1'b0;
  logic [31:0] s_rdata = 32'd0;
  logic        s1_ready = 1'b0;

  assign mem_if.mem_ready  = s_ready | s_extra;
  assign mem_if.mem_rdata  = s_rdata;
  assign mem1_if.mem_ready = s1_ready;
  assign mem1_if.mem_rdata = 32'd0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[0]   <= 32'h0060_0113;
      mem_init <= 1'b1;
      s_ready  <= 1'b0;
    end else if (mem_if.mem_valid && !s_ready) begin
      s_ready <= 1'b1;
      s_rdata <= mem[mem_if.mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_if.mem_wstrb[b]) mem[mem_if.mem_addr[9:2]][8*b +: 8] <= mem_if.mem_wdata[8*b +: 8];
    end else begin
      s_ready <= 1'b0;
    end
  end

  always @(posedge clk) s1_ready <= mem1_if.mem_valid && !s1_ready;

  // Monitor: grant starts, ready pulses and the bubble after each completion.
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] prev_grant1 = 2'b00;
  bit         prev_rdy = 1'b0;
  gnt_t       mon_g;
  rsp_t       mon_r;
  logic [1:0] mon_g1;

  initial begin
    forever begin
      @(negedge clk);
      if (prev_rdy) begin
        checks++;
        if (grant !== 2'b00) begin
          errors++;
          $display("FAIL bubble: grant=%b required 00", grant);
        end
      end
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: grant=%b addr=%h required no grant", grant, mem_if.mem_addr);
        end else begin
          mon_g = gnt_q.pop_front();
          if (grant !== mon_g.g || mem_if.mem_addr !== mon_g.addr ||
              mem_if.mem_instr !== mon_g.instr || mem_if.mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL grant: got grant=%b addr=%0d instr=%b valid=%b required grant=%b addr=%0d instr=%b valid=1",
                     grant, mem_if.mem_addr, mem_if.mem_instr, mem_if.mem_valid,
                     mon_g.g, mon_g.addr, mon_g.instr);
          end
        end
      end
      if (cpu_if.mem_ready) begin
        checks++;
        if (cpu_q.size() == 0) begin
          errors++;
          $display("FAIL cpu_ready_unexpected: ready=1 required 0");
        end else begin
          mon_r = cpu_q.pop_front();
          if (mon_r.chk && cpu_if.mem_rdata !== mon_r.rdata) begin
            errors++;
            $display("FAIL cpu_rdata: got %h required %h", cpu_if.mem_rdata, mon_r.rdata);
          end
        end
      end
      if (vec_if.mem_ready) begin
        checks++;
        if (vec_q.size() == 0) begin
          errors++;
          $display("FAIL vec_ready_unexpected: ready=1 required 0");
        end else begin
          mon_r = vec_q.pop_front();
          if (mon_r.chk && vec_if.mem_rdata !== mon_r.rdata) begin
            errors++;
            $display("FAIL vec_rdata: got %h required %h", vec_if.mem_rdata, mon_r.rdata);
          end
        end
      end
      if (grant1 != 2'b00 && prev_grant1 == 2'b00) begin
        checks++;
        if (gnt1_q.size() == 0) begin
          errors++;
          $display("FAIL grant1_unexpected: grant=%b required no grant", grant1);
        end else begin
          mon_g1 = gnt1_q.pop_front();
          if (grant1 !== mon_g1) begin
            errors++;
            $display("FAIL grant1: got %b required %b", grant1, mon_g1);
          end
        end
      end
      prev_rdy    = cpu_if.mem_ready | vec_if.mem_ready;
      prev_grant  = grant;
      prev_grant1 = grant1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_cpu_ready();
    int n = 0;
    do begin @(negedge clk); n++; end while (!cpu_if.mem_ready && n < 50);
    chk("cpu_ready_timeout", 32'(cpu_if.mem_ready), 32'd1);
  endtask

  task automatic wait_vec_ready();
    int n = 0;
    do begin @(negedge clk); n++; end while (!vec_if.mem_ready && n < 50);
    chk("vec_ready_timeout", 32'(vec_if.mem_ready), 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] t2_exp [10] = '{32'hA500_0064, 32'hA500_0066, 32'hA500_0069, 32'hA500_006B,
                               32'hA500_006E, 32'hA500_0070, 32'hA500_0073, 32'hA500_0075,
                               32'hA500_0078, 32'hA500_007A};
  logic [1:0] both_seq [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
  int n0;
  bit done0, done1;

  initial begin
    cpu_if.mem_valid = 0; cpu_if.mem_instr = 0; cpu_if.mem_addr = 0; cpu_if.mem_wdata = 0; cpu_if.mem_wstrb = 0;
    vec_if.mem_valid = 0; vec_if.mem_instr = 0; vec_if.mem_addr = 0; vec_if.mem_wdata = 0; vec_if.mem_wstrb = 0;
    cpu1_if.mem_valid = 0; cpu1_if.mem_instr = 0; cpu1_if.mem_addr = 0; cpu1_if.mem_wdata = 0; cpu1_if.mem_wstrb = 0;
    vec1_if.mem_valid = 0; vec1_if.mem_instr = 0; vec1_if.mem_addr = 0; vec1_if.mem_wdata = 0; vec1_if.mem_wstrb = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_if.mem_ready), 32'd0);
    chk("rst_vec_ready", 32'(vec_if.mem_ready), 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // CPU fetch from address 0
    gnt_q.push_back('{2'b01, 32'd0, 1'b1});
    cpu_q.push_back('{32'h0060_0113, 1'b1});
    cpu_if.mem_valid = 1; cpu_if.mem_instr = 1; cpu_if.mem_addr = 0;
    chk("fetch_req_cycle_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    @(negedge clk);
    chk("fetch_mem_valid", 32'(mem_if.mem_valid), 32'd1);
    chk("fetch_mem_instr", 32'(mem_if.mem_instr), 32'd1);
    wait_cpu_ready();
    cpu_if.mem_valid = 0; cpu_if.mem_instr = 0;
    @(negedge clk);
    chk("fetch_grant_after", 32'(grant), 32'd0);

    // Vector strided load: 10 words from 400, stride 10 bytes
    for (int k = 0; k < 10; k++) begin
      gnt_q.push_back('{2'b10, 32'(400 + 10 * k), 1'b0});
      vec_q.push_back('{t2_exp[k], 1'b1});
    end
    for (int k = 0; k < 10; k++) begin
      vec_if.mem_addr = 32'(400 + 10 * k);
      vec_if.mem_valid = 1;
      wait_vec_ready();
    end
    vec_if.mem_valid = 0;
    repeat (2) @(negedge clk);

    // Both masters requesting continuously; second instance has VEC_BURST=1
    do_reset();
    for (int k = 0; k < 10; k++) begin
      gnt_q.push_back('{both_seq[k], (both_seq[k] == 2'b10) ? 32'h40 : 32'h20, 1'b0});
      if (both_seq[k] == 2'b10) vec_q.push_back('{32'hA500_0010, 1'b1});
      else                      cpu_q.push_back('{32'hA500_0008, 1'b1});
    end
    for (int k = 0; k < 6; k++) gnt1_q.push_back((k % 2 == 0) ? 2'b10 : 2'b01);
    cpu_if.mem_addr = 32'h20; vec_if.mem_addr = 32'h40;
    cpu_if.mem_valid = 1; vec_if.mem_valid = 1;
    cpu1_if.mem_valid = 1; vec1_if.mem_valid = 1;
    n0 = 0; done0 = 0; done1 = 0;
    for (int c = 0; c < 300 && !(done0 && done1); c++) begin
      @(negedge clk);
      if (!done0 && (cpu_if.mem_ready || vec_if.mem_ready)) begin
        n0++;
        if (n0 == 10) begin cpu_if.mem_valid = 0; vec_if.mem_valid = 0; done0 = 1; end
      end
      if (!done1 && gnt1_q.size() == 0 && mem1_if.mem_ready) begin
        cpu1_if.mem_valid = 0; vec1_if.mem_valid = 0; done1 = 1;
      end
    end
    chk("both_done", {30'd0, done0, done1}, 32'd3);
    repeat (2) @(negedge clk);

    // Vector byte store to 600 racing a CPU read of the same word
    do_reset();
    gnt_q.push_back('{2'b10, 32'd600, 1'b0});
    gnt_q.push_back('{2'b01, 32'd600, 1'b0});
    vec_q.push_back('{32'd0, 1'b0});
    cpu_q.push_back('{32'hA500_0001, 1'b1});
    cpu_if.mem_addr = 600; cpu_if.mem_valid = 1;
    vec_if.mem_addr = 600; vec_if.mem_wdata = 32'h0000_0001; vec_if.mem_wstrb = 4'b0001; vec_if.mem_valid = 1;
    fork
      begin wait_vec_ready(); vec_if.mem_valid = 0; vec_if.mem_wstrb = 0; vec_if.mem_wdata = 0; end
      begin wait_cpu_ready(); cpu_if.mem_valid = 0; end
    join
    @(negedge clk);
    chk("store_mem150", mem[150], 32'hA500_0001);

    // Reset while VEC_BUSY with the slave answering next cycle
    gnt_q.push_back('{2'b10, 32'h40, 1'b0});
    vec_if.mem_addr = 32'h40; vec_if.mem_valid = 1;
    @(negedge clk);
    chk("rstmid_busy_grant", 32'(grant), 32'd2);
    resetn = 1'b0;
    vec_if.mem_valid = 0;
    cpu_if.mem_addr = 32'h20; cpu_if.mem_valid = 1;
    gnt_q.push_back('{2'b01, 32'h20, 1'b0});
    cpu_q.push_back('{32'hA500_0008, 1'b1});
    @(negedge clk);
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    chk("rstmid_vec_ready", 32'(vec_if.mem_ready), 32'd0);
    resetn = 1'b1;
    wait_cpu_ready();
    cpu_if.mem_valid = 0;
    repeat (2) @(negedge clk);

    // Stray slave ready while IDLE
    s_extra = 1;
    #1;
    chk("idle_rdy_cpu_ready", 32'(cpu_if.mem_ready), 32'd0);
    chk("idle_rdy_vec_ready", 32'(vec_if.mem_ready), 32'd0);
    @(negedge clk);
    s_extra = 0;
    chk("idle_rdy_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("idle_rdy_grant_after", 32'(grant), 32'd0);

    repeat (4) @(negedge clk);
    chk("queues_empty", 32'(gnt_q.size() + cpu_q.size() + vec_q.size() + gnt1_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
